// File: rtl/cic_pkg.sv
// Shared helpers for the variable-rate multi-channel CIC decimator.
// Width derivation and saturation limits used by top and channel.
package cic_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int acc_width(
    input int in_w,
    input int stages,
    input int rate_w
  );
    return in_w + stages * rate_w;
  endfunction

  function automatic logic [255:0] sat_max(input int w);
    return (256'd1 << (w - 1)) - 256'd1;
  endfunction

  function automatic logic [255:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction

endpackage

// File: rtl/cic_channel.sv
// One CIC channel: integrator cascade, comb chain and output scaler.
// Timebase (strobe) and shift are shared across channels by the top.
module cic_channel
  import cic_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32,
  parameter int STAGES    = 5,
  parameter int ACC_WIDTH = 96,
  parameter int SHIFT_W   = 7
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic                        strobe,
  input  logic [SHIFT_W-1:0]          shift,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_sat
);

  localparam int SH_MAX = ACC_WIDTH - OUT_WIDTH;
  localparam logic [255:0] MAX_W = sat_max(OUT_WIDTH);
  localparam logic [255:0] MIN_W = sat_min(OUT_WIDTH);
  localparam logic signed [ACC_WIDTH:0] V_MAX = $signed(MAX_W[ACC_WIDTH:0]);
  localparam logic signed [ACC_WIDTH:0] V_MIN = $signed(MIN_W[ACC_WIDTH:0]);
  localparam logic signed [ACC_WIDTH:0] ONE = {{ACC_WIDTH{1'b0}}, 1'b1};

  typedef logic [ACC_WIDTH-1:0] acc_t;

  acc_t integ_q [STAGES];
  acc_t integ_d [STAGES];
  acc_t dly_q [STAGES];
  acc_t dly_d [STAGES];
  acc_t comb_y;

  logic [SHIFT_W-1:0]          sh;
  logic signed [ACC_WIDTH:0]   ext;
  logic signed [ACC_WIDTH:0]   rnd;
  logic signed [ACC_WIDTH:0]   v;
  logic signed [OUT_WIDTH-1:0] out_data_d, out_data_q;
  logic                        out_sat_d, out_sat_q;

  // Integrators wrap modulo 2^ACC_WIDTH on purpose; combs undo it.
  always_comb begin
    for (int k = 0; k < STAGES; k++)
      integ_d[k] = integ_q[k];
    if (in_valid) begin
      integ_d[0] = integ_q[0]
        + {{(ACC_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
      for (int k = 1; k < STAGES; k++)
        integ_d[k] = integ_q[k] + integ_q[k-1];
    end
  end

  always_comb begin : comb_chain
    acc_t x;
    x = integ_q[STAGES-1];
    for (int k = 0; k < STAGES; k++) begin
      dly_d[k] = strobe ? x : dly_q[k];
      x = x - dly_q[k];
    end
    comb_y = x;
  end

  always_comb begin
    sh = (int'(shift) > SH_MAX) ? SHIFT_W'(SH_MAX) : shift;
    ext = {comb_y[ACC_WIDTH-1], comb_y};
    rnd = (sh != '0) ? (ONE <<< (sh - SHIFT_W'(1))) : '0;
    v = (ext + rnd) >>> sh;
    out_data_d = out_data_q;
    out_sat_d = out_sat_q;
    if (strobe) begin
      if (v > V_MAX) begin
        out_data_d = V_MAX[OUT_WIDTH-1:0];
        out_sat_d = 1'b1;
      end else if (v < V_MIN) begin
        out_data_d = V_MIN[OUT_WIDTH-1:0];
        out_sat_d = 1'b1;
      end else begin
        out_data_d = v[OUT_WIDTH-1:0];
        out_sat_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        integ_q[k] <= '0;
        dly_q[k] <= '0;
      end
      out_data_q <= '0;
      out_sat_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        integ_q[k] <= integ_d[k];
        dly_q[k] <= dly_d[k];
      end
      out_data_q <= out_data_d;
      out_sat_q <= out_sat_d;
    end
  end

  assign out_data = out_data_q;
  assign out_sat = out_sat_q;

endmodule

// File: rtl/cic_decim_var.sv
// Multi-channel CIC decimator with run-time rate and output shift.
// Owns the shared decimation counter, rate latch and warm-up gate.
module cic_decim_var
  import cic_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32,
  parameter int STAGES    = 5,
  parameter int RATE_W    = 16,
  parameter int NUM_CH    = 2,
  parameter int ACC_WIDTH = acc_width(IN_WIDTH, STAGES, RATE_W),
  parameter int SHIFT_W   = clog2(ACC_WIDTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [NUM_CH*IN_WIDTH-1:0]  in_data,
  input  logic [RATE_W-1:0]           rate,
  input  logic [SHIFT_W-1:0]          shift,
  output logic [NUM_CH*OUT_WIDTH-1:0] out_data,
  output logic                        out_valid,
  output logic [NUM_CH-1:0]           out_sat
);

  localparam int WARM_W = clog2(STAGES + 1);

  typedef logic [WARM_W-1:0] warm_t;

  localparam warm_t WARM_INIT = warm_t'(STAGES);

  logic [RATE_W-1:0] count_d, count_q;
  logic [RATE_W-1:0] rate_d, rate_q;
  warm_t             warm_d, warm_q;
  logic              out_valid_d, out_valid_q;
  logic              strobe;

  assign strobe = in_valid && (count_q == rate_q);

  // Rate is only taken at a frame boundary; a new value re-arms warm-up.
  always_comb begin
    count_d = count_q;
    rate_d = rate_q;
    warm_d = warm_q;
    out_valid_d = 1'b0;
    if (strobe) begin
      count_d = '0;
      rate_d = rate;
      out_valid_d = (warm_q == '0);
      if (rate != rate_q)
        warm_d = WARM_INIT;
      else if (warm_q != '0)
        warm_d = warm_q - warm_t'(1);
    end else if (in_valid) begin
      count_d = count_q + RATE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      rate_q <= rate;
      warm_q <= WARM_INIT;
      out_valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      rate_q <= rate_d;
      warm_q <= warm_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    cic_channel #(
      .IN_WIDTH  (IN_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .STAGES    (STAGES),
      .ACC_WIDTH (ACC_WIDTH),
      .SHIFT_W   (SHIFT_W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .strobe   (strobe),
      .shift    (shift),
      .in_data  (in_data[c*IN_WIDTH +: IN_WIDTH]),
      .out_data (out_data[c*OUT_WIDTH +: OUT_WIDTH]),
      .out_sat  (out_sat[c])
    );
  end

endmodule
